serial_parity_checker: RTL and testbench
========================================

# serial_parity_checker

Receive side of the team's serial parity path. Accepts a 17-bit serial frame (16 data bits LSB-first, then one parity bit), one bit per DVALID strobe. It rebuilds the 16-bit word, counts its set bits, and flags a parity mismatch. Its 5-bit CNT output has the same meaning as the generator's CNT, so it drives the existing multiplexed display directly. It sits between a bit source (switch/button debounce logic or a generator loopback) and the display.

## Interface

Parameters:
- EVEN_PARITY, 1, 1 = even parity (ones in data plus parity bit must be even); 0 = odd parity.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle strobe that begins a new frame.
- DIN  input  1  serial data bit; sampled only when DVALID=1.
- DVALID  input  1  bit strobe; one bit is consumed per cycle it is high.
- WORD  output  16  last completed data word.
- CNT  output  5  number of set bits in WORD, 0..16.
- PAR_ERR  output  1  parity check failed for the last completed frame.
- DONE  output  1  one-cycle pulse when WORD, CNT and PAR_ERR update.
- BUSY  output  1  high while a frame is in progress (DATA or PARITY state).

## Operation

- FSM states: IDLE, DATA, PARITY, DONE.
  - IDLE: DVALID is ignored. START moves the FSM to DATA and clears the shadow word, the ones counter and the bit index.
  - DATA: on each DVALID, DIN shifts in at bit position index (LSB first), ones += DIN, index += 1. On the DVALID with index=15, the FSM goes to PARITY.
  - PARITY: the next DVALID samples DIN as the parity bit. That edge loads WORD from the shadow word and CNT from the ones counter. PAR_ERR is loaded as: for EVEN_PARITY=1, ones[0] XOR DIN; for EVEN_PARITY=0, NOT(ones[0] XOR DIN). The FSM goes to DONE.
  - DONE: DONE=1 for exactly this cycle, then the FSM returns to IDLE unconditionally. A START during DONE is honoured as in IDLE.
- Width rules:
  - Ones counter is 5 bits and saturates naturally at 16; no overflow is possible.
  - Bit index is 4 bits and does not wrap, because it leaves DATA at 15.
- Outputs WORD, CNT and PAR_ERR change only on frame completion. They hold between frames and during partial frames.
- START during DATA or PARITY aborts the current frame and restarts in DATA. The partial data is discarded and the outputs are unchanged.
- START and DVALID in the same cycle: START wins and that bit is not consumed, in every state.
- Gaps in DVALID of any length are allowed. There is no timeout.

## Timing

- Reset values: WORD=0, CNT=0, PAR_ERR=0, DONE=0, BUSY=0, FSM=IDLE. RST overrides all other inputs.
- RST mid-frame: the frame is discarded and reset values apply on the next edge.
- START at edge n: BUSY=1 after edge n. The first DVALID can be consumed at edge n+1.
- The parity bit is consumed at edge p. WORD, CNT and PAR_ERR are valid and DONE=1 after edge p, and BUSY=0 after edge p.
- After edge p+1, DONE=0.
- Minimum frame: START plus 17 consecutive DVALID cycles equals 18 cycles to the DONE pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Reset, then send START and frame 0xA5A5 (8 ones) with parity bit 0, EVEN_PARITY=1. Required: DONE for one cycle, WORD=0xA5A5, CNT=8, PAR_ERR=0.
- Send 0xFFFF with parity bit 1, EVEN_PARITY=1. Required: CNT=16, PAR_ERR=1. Repeat with EVEN_PARITY=0: PAR_ERR=0.
- Send 0x0001 with parity bit 1 and random 0–5 cycle gaps between DVALID strobes. Required: WORD=0x0001, CNT=1, PAR_ERR=0, and DONE exactly 1 cycle after the 17th strobe.
- After a completed 0x1234 frame, send 9 bits of a new frame, then START (with DVALID=1 in the same cycle), then a full frame 0x8000 with parity bit 1. Required: WORD stays 0x1234 until the new DONE, then WORD=0x8000, CNT=1, PAR_ERR=0.
- Assert RST after 10 bits of a frame. Required: after the next edge all outputs are 0 and BUSY=0. Further DVALID strobes without START produce no DONE.
- DVALID pulses in IDLE without START. Required: no state change, and WORD/CNT remain at their prior values.

Source files
------------

// File: rtl/serial_parity_checker.sv
// Serial parity checker: rebuilds a 16-bit LSB-first word plus a parity bit, counts ones, flags mismatch.
// Latency: outputs update on the edge that consumes the parity bit; DONE pulses for the following cycle.
// Backpressure: none; one bit consumed per DVALID cycle, any gap length allowed, START aborts/restarts.
//
// Ports:
//   CLK, RST           clock and synchronous active-high reset
//   START              one-cycle strobe beginning a new frame (wins over DVALID)
//   DIN, DVALID        serial bit and its strobe
//   WORD, CNT          last completed data word and its number of set bits
//   PAR_ERR            parity check result of the last completed frame
//   DONE, BUSY         completion pulse and frame-in-progress flag
module serial_parity_checker #(
   parameter bit EVEN_PARITY = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic        DIN,
   input  logic        DVALID,
   output logic [15:0] WORD,
   output logic [4:0]  CNT,
   output logic        PAR_ERR,
   output logic        DONE,
   output logic        BUSY
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] shadow_q, shadow_d;
   logic [4:0]  ones_q, ones_d;
   logic [3:0]  idx_q, idx_d;
   logic [15:0] word_q, word_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        par_err_q, par_err_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         shadow_q  <= '0;
         ones_q    <= '0;
         idx_q     <= '0;
         word_q    <= '0;
         cnt_q     <= '0;
         par_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         ones_q    <= ones_d;
         idx_q     <= idx_d;
         word_q    <= word_d;
         cnt_q     <= cnt_d;
         par_err_q <= par_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      ones_d    = ones_q;
      idx_d     = idx_q;
      word_d    = word_q;
      cnt_d     = cnt_q;
      par_err_d = par_err_q;

      // START is honoured in every state and takes priority over a
      // simultaneous DVALID; the bit offered alongside it is dropped.
      if (START) begin
         state_d  = S_DATA;
         shadow_d = '0;
         ones_d   = '0;
         idx_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end
            S_DATA: begin
               if (DVALID) begin
                  shadow_d[idx_q] = DIN;
                  ones_d          = ones_q + {4'd0, DIN};
                  idx_d           = idx_q + 4'd1;
                  if (idx_q == 4'd15) begin
                     state_d = S_PARITY;
                  end
               end
            end
            S_PARITY: begin
               if (DVALID) begin
                  word_d = shadow_q;
                  cnt_d  = ones_q;
                  // Only the LSB of the ones count matters for parity.
                  if (EVEN_PARITY) begin
                     par_err_d = ones_q[0] ^ DIN;
                  end else begin
                     par_err_d = ~(ones_q[0] ^ DIN);
                  end
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Every output is derived from registered state only.
   assign WORD    = word_q;
   assign CNT     = cnt_q;
   assign PAR_ERR = par_err_q;
   assign DONE    = (state_q == S_DONE);
   assign BUSY    = (state_q == S_DATA) || (state_q == S_PARITY);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd parity instances share the stimulus.
module tb_serial_parity_checker;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic        DIN;
   logic        DVALID;

   logic [15:0] word_e, word_o;
   logic [4:0]  cnt_e, cnt_o;
   logic        perr_e, perr_o;
   logic        done_e, done_o;
   logic        busy_e, busy_o;

   int n_checks = 0;
   int n_errors = 0;

   // Reference view of the last completed frame.
   logic [15:0] exp_word;
   logic [4:0]  exp_cnt;
   logic        exp_perr_e;
   logic        exp_perr_o;

   always #5 CLK = ~CLK;

   serial_parity_checker #(.EVEN_PARITY(1'b1)) u_even (
      .CLK(CLK), .RST(RST), .START(START), .DIN(DIN), .DVALID(DVALID),
      .WORD(word_e), .CNT(cnt_e), .PAR_ERR(perr_e), .DONE(done_e), .BUSY(busy_e)
   );

   serial_parity_checker #(.EVEN_PARITY(1'b0)) u_odd (
      .CLK(CLK), .RST(RST), .START(START), .DIN(DIN), .DVALID(DVALID),
      .WORD(word_o), .CNT(cnt_o), .PAR_ERR(perr_o), .DONE(done_o), .BUSY(busy_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_hold(input string tag);
      check({tag, "_word_e"}, {16'd0, word_e}, {16'd0, exp_word});
      check({tag, "_word_o"}, {16'd0, word_o}, {16'd0, exp_word});
      check({tag, "_cnt"},    {27'd0, cnt_e},  {27'd0, exp_cnt});
      check({tag, "_perr_e"}, {31'd0, perr_e}, {31'd0, exp_perr_e});
      check({tag, "_perr_o"}, {31'd0, perr_o}, {31'd0, exp_perr_o});
   endtask

   task automatic check_flags(input string tag, input logic done, input logic busy);
      check({tag, "_done_e"}, {31'd0, done_e}, {31'd0, done});
      check({tag, "_done_o"}, {31'd0, done_o}, {31'd0, done});
      check({tag, "_busy_e"}, {31'd0, busy_e}, {31'd0, busy});
      check({tag, "_busy_o"}, {31'd0, busy_o}, {31'd0, busy});
   endtask

   task automatic do_start(input logic with_dv);
      START  = 1'b1;
      DVALID = with_dv;
      DIN    = 1'b1;
      tick();
      START  = 1'b0;
      DVALID = 1'b0;
      check_flags("start", 1'b0, 1'b1);
      check_hold("start");
   endtask

   // Sends nbits of the frame (data LSB first, then parity) with random gaps.
   // When the 17th bit goes in, the model is updated and the completion checked.
   task automatic send_bits(input logic [15:0] w, input logic p, input int nbits, input int maxgap);
      int ones;
      for (int i = 0; i < nbits; i++) begin
         repeat ($urandom_range(maxgap, 0)) begin
            DVALID = 1'b0;
            DIN    = 1'($urandom);
            tick();
            check_flags("gap", 1'b0, 1'b1);
         end
         DIN    = (i < 16) ? w[i] : p;
         DVALID = 1'b1;
         tick();
         DVALID = 1'b0;
         if (i < 16) begin
            check_flags("bit", 1'b0, 1'b1);
            check_hold("bit");
         end else begin
            ones       = $countones(w);
            exp_word   = w;
            exp_cnt    = 5'(ones);
            exp_perr_e = ((ones + int'(p)) % 2) != 0;
            exp_perr_o = ((ones + int'(p)) % 2) == 0;
            check_flags("done", 1'b1, 1'b0);
            check_hold("done");
            tick();
            check_flags("after_done", 1'b0, 1'b0);
            check_hold("after_done");
         end
      end
   endtask

   task automatic frame(input logic [15:0] w, input logic p, input int maxgap);
      do_start(1'b0);
      send_bits(w, p, 17, maxgap);
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; DIN = 1'b0; DVALID = 1'b0;
      exp_word = '0; exp_cnt = '0; exp_perr_e = 1'b0; exp_perr_o = 1'b0;
      tick();
      tick();
      check_flags("reset", 1'b0, 1'b0);
      check_hold("reset");
      RST = 1'b0;
      tick();

      // Directed frames.
      frame(16'hA5A5, 1'b0, 0);
      check("a5a5_cnt", {27'd0, cnt_e}, 32'd8);
      frame(16'hFFFF, 1'b1, 0);
      check("ffff_cnt", {27'd0, cnt_e}, 32'd16);
      check("ffff_perr_e", {31'd0, perr_e}, 32'd1);
      check("ffff_perr_o", {31'd0, perr_o}, 32'd0);
      frame(16'h0001, 1'b1, 5);

      // Abort mid-frame, then restart with START and DVALID together.
      frame(16'h1234, 1'b0, 0);
      do_start(1'b0);
      send_bits(16'($urandom), 1'b0, 9, 2);
      do_start(1'b1);
      send_bits(16'h8000, 1'b1, 17, 0);
      check("8000_perr_e", {31'd0, perr_e}, 32'd0);

      // START during the DONE cycle starts the next frame immediately.
      do_start(1'b0);
      send_bits(16'h00FF, 1'b1, 16, 0);
      DIN = 1'b1; DVALID = 1'b1;
      tick();
      DVALID = 1'b0;
      exp_word = 16'h00FF; exp_cnt = 5'd8; exp_perr_e = 1'b1; exp_perr_o = 1'b0;
      check_flags("ff_done", 1'b1, 1'b0);
      check_hold("ff_done");
      do_start(1'b0);
      send_bits(16'h0F0F, 1'b0, 17, 1);

      // Reset in the middle of a frame.
      do_start(1'b0);
      send_bits(16'hBEEF, 1'b1, 10, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      exp_word = '0; exp_cnt = '0; exp_perr_e = 1'b0; exp_perr_o = 1'b0;
      check_flags("rst_mid", 1'b0, 1'b0);
      check_hold("rst_mid");
      for (int i = 0; i < 20; i++) begin
         DIN = 1'($urandom); DVALID = 1'b1;
         tick();
         check_flags("rst_idle", 1'b0, 1'b0);
      end
      DVALID = 1'b0;
      check_hold("rst_idle");

      // DVALID in IDLE after a completed frame leaves everything alone.
      frame(16'h5A3C, 1'b1, 0);
      for (int i = 0; i < 12; i++) begin
         DIN = 1'($urandom); DVALID = 1'($urandom);
         tick();
         check_flags("idle_dv", 1'b0, 1'b0);
      end
      DVALID = 1'b0;
      check_hold("idle_dv");

      // Random frames with random gaps.
      for (int k = 0; k < 25; k++) begin
         frame(16'($urandom), 1'($urandom), int'($urandom_range(3, 0)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
